// File: rtl/fibonacci_uart_rx_pkg.sv
// Shared definitions for the fibonacci UART receive path.
//   rx_state_t     : receiver FSM states, 3-bit encoding, shared with tx tooling
//   UART_DATA_BITS : data bits per 8N1 frame (fixed at 8)
package fibonacci_uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/fibonacci_uart_rx_if.sv
// Byte hand-off between the UART receiver and the command logic.
//   data       : received byte, stable while data_valid is high
//   data_valid : level, high from byte capture until accepted
//   data_ack   : consumer accepts the byte; only meaningful while data_valid=1
// Handshake: a byte transfers on any clock edge where data_valid=1 and
// data_ack=1. data_valid then drops unless a new byte is committed on that
// same edge. data_ack while data_valid=0 has no effect.
// master = receiver (producer), slave = consumer.
interface fibonacci_uart_rx_if;
    import fibonacci_uart_rx_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      data_valid;
    logic                      data_ack;

    modport master (output data, output data_valid, input data_ack);
    modport slave  (input data, input data_valid, output data_ack);
endinterface

// File: rtl/fibonacci_uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
//   clk   : destination clock
//   nRst  : asynchronous active-low reset, flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module fibonacci_uart_rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fibonacci_uart_rx.sv
// UART 8N1 receiver with a one-entry holding register.
//   clk        : system clock, rising edge
//   nRst       : asynchronous active-low reset
//   rx         : raw serial input, idle high, asynchronous to clk
//   bus        : byte hand-off (data / data_valid / data_ack), master side
//   busy       : high while a frame is in progress (state != IDLE)
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   overrun    : 1-cycle pulse, byte completed while holding register full
//   dbg_state  : current FSM state, for observation only
module fibonacci_uart_rx
    import fibonacci_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      rx,
    fibonacci_uart_rx_if.master       bus,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun,
    output rx_state_t                 dbg_state
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      commit;

    fibonacci_uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .nRst (nRst),
        .d    (rx),
        .q    (rx_s)
    );

    // A good stop bit at its centre hands the byte to the holding register.
    assign commit    = (state == ST_STOP) && (baud_cnt == BAUD_LAST) && rx_s;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state          <= ST_IDLE;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            busy           <= 1'b0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                        end else begin
                            // Line went high again before mid start bit: glitch.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift    <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            // Leave at mid stop bit so a following start edge is seen.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ST_BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    baud_cnt <= '0;
                    // A line held low must return high before a new frame can start.
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase

            // Holding register: an ack in the same cycle as a commit frees the slot.
            if (commit) begin
                if (!bus.data_valid || bus.data_ack) begin
                    bus.data       <= shift;
                    bus.data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (bus.data_ack) begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fibonacci_uart_rx.sv
module tb_fibonacci_uart_rx;
    import fibonacci_uart_rx_pkg::*;

    localparam int CPB = 16;

    logic      clk = 1'b0;
    logic      nRst;
    logic      rx;
    logic      busy;
    logic      frame_err;
    logic      overrun;
    rx_state_t dbg_state;

    fibonacci_uart_rx_if u_if ();

    fibonacci_uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx        (rx),
        .bus       (u_if.master),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model of the holding register and error pulses.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_over  = 0;
    int         m_ferr  = 0;

    // Pulse monitors, sampled away from the active edge.
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int busy_run = 0;
    int busy_max = 0;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    // Model of a well-formed frame arriving at the holding register.
    function automatic void model_commit(input logic [7:0] b);
        if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            m_over++;
        end
    endfunction

    task automatic pulse_ack();
        u_if.data_ack = 1'b1;
        @(negedge clk);
        u_if.data_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {31'b0, u_if.data_valid}, {31'b0, m_valid});
        if (m_valid) check({tag, ".data"}, {24'b0, u_if.data}, {24'b0, m_data});
        check({tag, ".overrun"}, ov_cnt, m_over);
        check({tag, ".frame_err"}, fe_cnt, m_ferr);
    endtask

    initial begin
        int lat;
        logic [7:0] rb;

        nRst = 1'b0;
        rx = 1'b1;
        u_if.data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.data", {24'b0, u_if.data}, 32'h0);
        check("rst.valid", {31'b0, u_if.data_valid}, 32'h0);
        check("rst.busy", {31'b0, busy}, 32'h0);
        check("rst.state", {29'b0, dbg_state}, 32'(ST_IDLE));
        nRst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single frame, latency from start edge to data_valid.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!u_if.data_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        model_commit(8'hA5);
        check("t1.lat_in_window", {31'b0, (lat >= 154 && lat <= 156)}, 32'h1);
        check_model("t1");
        pulse_ack();
        check("t1.ack_clears", {31'b0, u_if.data_valid}, 32'h0);

        // 2: back-to-back frames, ack during the second start bit.
        send_frame(8'h01, 1'b1);
        model_commit(8'h01);
        fork
            send_frame(8'h80, 1'b1);
            begin
                check_model("t2a");
                pulse_ack();
            end
        join
        model_commit(8'h80);
        check_model("t2b");
        pulse_ack();

        // 3: two frames, no ack -> overrun, first byte retained.
        send_frame(8'h3C, 1'b1);
        model_commit(8'h3C);
        send_frame(8'hC3, 1'b1);
        model_commit(8'hC3);
        check_model("t3");
        pulse_ack();

        // 4: bad stop bit -> frame_err, BREAK until line high.
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        m_ferr++;
        check_model("t4");
        repeat (20) @(negedge clk);
        check("t4.break_held", {29'b0, dbg_state}, 32'(ST_BREAK));
        check("t4.busy_break", {31'b0, busy}, 32'h1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("t4.idle", {29'b0, dbg_state}, 32'(ST_IDLE));

        // 5: short glitch is rejected.
        busy_max = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t5.busy_short", {31'b0, (busy_max > 0 && busy_max <= 10)}, 32'h1);
        check("t5.idle", {29'b0, dbg_state}, 32'(ST_IDLE));
        check_model("t5");

        // Random frames with random idle gaps and random acks.
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            send_frame(rb, 1'b1);
            model_commit(rb);
            check_model("rnd");
        end

        // 6: reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        nRst = 1'b0;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6.rst_valid", {31'b0, u_if.data_valid}, 32'h0);
        check("t6.rst_data", {24'b0, u_if.data}, 32'h0);
        check("t6.rst_busy", {31'b0, busy}, 32'h0);
        check("t6.rst_state", {29'b0, dbg_state}, 32'(ST_IDLE));
        rx = 1'b1;
        nRst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h12, 1'b1);
        model_commit(8'h12);
        check_model("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
